cplx_poly_engine: RTL
=====================

CPLX_POLY_ENGINE -- requirements
Module: cplx_poly_engine

Interface
REQ-001 Parameter N, default 2, meaning terms per operand polynomial; legal range 2..8.
REQ-002 Parameter W, default 8, meaning component width; must be even, legal range 4..16.
REQ-003 Derived CW = 2W + clog2(N) + 1, the signed result component width; OUT_W = 2*CW; NOUT = 2N-1.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  input word qualifier.
REQ-007 in  input  2W  input word {real[2W-1:W], imag[W-1:0]}, each component two's-complement signed.
REQ-008 in_mode  input  1  frame mode, sampled with the first word only: 0 = complex product, 1 = nibble statistics.
REQ-009 in_ready  output  1  high when a word presented with in_valid is accepted.
REQ-010 out_valid  output  1  output result qualifier.
REQ-011 out  output  OUT_W  result word.
REQ-012 out_last  output  1  high with the final result of a frame.

Function
REQ-013 A frame is 2N words accepted on consecutive cycles: a[0..N-1] first, then b[0..N-1].
REQ-014 The FSM shall have states IDLE, LOAD, OUT; in_ready = 1 in IDLE and LOAD, 0 in OUT.
REQ-015 IDLE: in_valid=1 -> store a[0], latch in_mode, word count=1, go to LOAD; otherwise stay.
REQ-016 LOAD: in_valid=1 -> store word at count, increment count; on word 2N-1 -> go to OUT, result index=0.
REQ-017 LOAD: in_valid=0 -> abort: discard the partial frame, go to IDLE, no output for that frame.
REQ-018 OUT: each edge registers result[index] into out, sets out_valid=1, increments index; out_last=1 and next state=IDLE when index=NOUT-1 (mode 0) or 2 (mode 1).
REQ-019 in_valid in OUT shall be ignored; no words are stored.
REQ-020 Latency: if the last frame word is captured on edge T, out_valid=1 on edges T+1 .. T+R, where R = NOUT (mode 0) or 3 (mode 1), with no gaps.
REQ-021 When out_valid=0, out=0 and out_last=0.
REQ-022 Mode 0: c[k] = sum over i+j=k of conj(a[i])*b[j], for k=0..NOUT-1.
REQ-023 Each term: real = ar*br + ai*bi; imag = ar*bi - ai*br; full-precision signed arithmetic, sign-extended to CW; no saturation or truncation.
REQ-024 Mode 0 out = {c[k].real[CW-1:0], c[k].imag[CW-1:0]}, results in ascending k.
REQ-025 Mode 1: consider all 4-bit unsigned nibbles of all 2N stored words (2N*W/2 nibbles).
REQ-026 Mode 1 shall emit, in order, max nibble, min nibble, max-min, each zero-extended to OUT_W.
REQ-027 Back-to-back: the state returns to IDLE on the edge that emits out_last, so a new frame's first word may be accepted in the same cycle out_last is high.
REQ-028 The mode latched for a frame shall not change until that frame's outputs complete.

Reset
REQ-029 rst_n=0 shall immediately force state=IDLE, counts=0, out_valid=0, out=0, out_last=0; in_ready=1.
REQ-030 Reset asserted mid-load or mid-output shall discard the frame; no further outputs from it.
REQ-031 Operand storage need not be reset.

Verification (N=2, W=8; CW=18, OUT_W=36)
REQ-032 Mode 0, words 0x0102, 0x0304, 0x0506, 0x0708 -> three cycles (real, imag) = (17, -4), (62, -8), (53, -4); out_last on the third.
REQ-033 Mode 0, all four words 0x8080 -> (32768, 0), (65536, 0), (32768, 0); no overflow at CW=18.
REQ-034 Mode 1, same words as REQ-032 -> out = 8, 0, 8; out_valid high for exactly 3 cycles starting one edge after the 4th word.
REQ-035 Mode 1, words 0xFFFF, 0x7FFF, 0xFFFF, 0xFFFF -> out = 15, 7, 8.
REQ-036 Abort: drop in_valid after 2 words -> no out_valid, in_ready stays 1; the following full REQ-032 frame produces correct results.
REQ-037 Assert rst_n=0 during the 2nd output cycle -> out_valid, out and out_last are 0 at once; in_valid held during OUT is ignored, and a new frame sent starting in the out_last cycle is accepted.

Source files
------------

// File: rtl/cplx_poly_engine.sv
`timescale 1ns/1ps
// cplx_poly_engine: collects a frame of 2N complex words (a[] then b[]) and
// emits either the conjugate polynomial product c = conj(a) * b (mode 0) or
// max/min/range statistics over all 4-bit nibbles of the frame (mode 1).
//
// Handshake: a word transfers on any rising edge where in_valid && in_ready.
// in_ready is high in IDLE and LOAD and low in OUT. out_valid qualifies out
// for exactly one cycle per result, with no back-pressure. out and out_last
// are zero whenever out_valid is low.
module cplx_poly_engine #(
  parameter int N = 2,
  parameter int W = 8,
  localparam int CW = 2 * W + $clog2(N) + 1,
  localparam int OUT_W = 2 * CW,
  localparam int NOUT = 2 * N - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [2*W-1:0]   in,
  input  logic             in_mode,
  output logic             in_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] out,
  output logic             out_last,
  output logic [1:0]       state_dbg
);

  localparam int AW = $clog2(2 * N);
  localparam logic [AW-1:0] LAST_WORD = AW'(2 * N - 1);
  localparam logic [AW-1:0] LAST_CPLX = AW'(NOUT - 1);
  localparam logic [AW-1:0] LAST_STAT = AW'(2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [AW-1:0]    count;
  logic [AW-1:0]    idx;
  logic [AW-1:0]    last_idx;
  logic             mode;
  logic [2*W-1:0]   mem [2*N];
  logic [OUT_W-1:0] result;

  logic signed [CW-1:0] acc_re, acc_im, ar, ai, br, bi;
  logic [3:0]           nib, nib_max, nib_min;

  assign state_dbg = state;
  assign last_idx  = mode ? LAST_STAT : LAST_CPLX;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: a gap in in_valid during LOAD abandons the frame.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (in_valid) state_nxt = S_LOAD;
      S_LOAD: begin
        if (!in_valid)               state_nxt = S_IDLE;
        else if (count == LAST_WORD) state_nxt = S_OUT;
      end
      S_OUT:  if (idx == last_idx) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    in_ready = (state != S_OUT);
  end

  // Counters, frame mode and registered result port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      idx       <= '0;
      mode      <= 1'b0;
      out_valid <= 1'b0;
      out       <= '0;
      out_last  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out       <= '0;
      out_last  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            mode  <= in_mode;
            count <= AW'(1);
          end
        end
        S_LOAD: begin
          if (!in_valid) begin
            count <= '0;
          end else if (count == LAST_WORD) begin
            count <= '0;
            idx   <= '0;
          end else begin
            count <= count + AW'(1);
          end
        end
        S_OUT: begin
          out_valid <= 1'b1;
          out       <= result;
          out_last  <= (idx == last_idx);
          idx       <= idx + AW'(1);
        end
        default: ;
      endcase
    end
  end

  // Operand storage; count is zero in IDLE, so the first word lands in slot 0.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) mem[count] <= in;
  end

  // Coefficient idx of conj(a) * b, accumulated at full precision in CW bits.
  always_comb begin
    acc_re = '0;
    acc_im = '0;
    ar = '0;
    ai = '0;
    br = '0;
    bi = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (i + j == int'(idx)) begin
          ar = CW'($signed(mem[AW'(i)][2*W-1:W]));
          ai = CW'($signed(mem[AW'(i)][W-1:0]));
          br = CW'($signed(mem[AW'(N + j)][2*W-1:W]));
          bi = CW'($signed(mem[AW'(N + j)][W-1:0]));
          acc_re = acc_re + ar * br + ai * bi;
          acc_im = acc_im + ar * bi - ai * br;
        end
      end
    end
  end

  // Largest and smallest unsigned nibble across every stored word.
  always_comb begin
    nib     = '0;
    nib_max = 4'h0;
    nib_min = 4'hf;
    for (int w = 0; w < 2 * N; w++) begin
      for (int n = 0; n < W / 2; n++) begin
        nib = mem[AW'(w)][4*n +: 4];
        if (nib > nib_max) nib_max = nib;
        if (nib < nib_min) nib_min = nib;
      end
    end
  end

  // Select the result for the current output index.
  always_comb begin
    result = '0;
    if (!mode)                result = {acc_re, acc_im};
    else if (idx == '0)       result = OUT_W'(nib_max);
    else if (idx == AW'(1))   result = OUT_W'(nib_min);
    else                      result = OUT_W'(nib_max - nib_min);
  end

endmodule
